// File: rtl/spram_bus_ctrl_if.sv
// CPU-side request/acknowledge bus of the SPRAM bus controller.
// The master (CPU) raises bus_cyc with a stable command and holds it until
// it sees the one-cycle bus_ack pulse; read data is valid with that pulse.
interface spram_bus_ctrl_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) ();
    logic              bus_cyc;
    logic              bus_write;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wrdata;
    logic [DATA_W-1:0] bus_rddata;
    logic              bus_ack;

    modport master (
        output bus_cyc,
        output bus_write,
        output bus_addr,
        output bus_wrdata,
        input  bus_rddata,
        input  bus_ack
    );

    modport slave (
        input  bus_cyc,
        input  bus_write,
        input  bus_addr,
        input  bus_wrdata,
        output bus_rddata,
        output bus_ack
    );
endinterface

// File: rtl/spram_bus_ctrl.sv
// Bridges a simple held-request CPU bus onto a single-port RAM with a fixed
// read latency. One access at a time: IDLE accepts, ISSUE drives the RAM,
// WAIT counts out the read latency, ACK pulses completion for one cycle.
// Every output is registered; dropping bus_cyc mid-access aborts it quietly.
module spram_bus_ctrl #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    spram_bus_ctrl_if.slave   bus,
    output logic [ADDR_W-1:0] spram_addr,
    output logic [DATA_W-1:0] spram_din,
    output logic              spram_wren,
    output logic              spram_cs,
    input  logic [DATA_W-1:0] spram_dout
);

    // Two bits cover the whole supported latency range (counter loads 0..3).
    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t            state,      state_nxt;
    logic              wr_flag,    wr_flag_nxt;
    logic [CNT_W-1:0]  cnt,        cnt_nxt;
    logic              ack,        ack_nxt;
    logic [DATA_W-1:0] rddata,     rddata_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] din_nxt;
    logic              wren_nxt;
    logic              cs_nxt;

    assign bus.bus_ack    = ack;
    assign bus.bus_rddata = rddata;

    // State and all registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wr_flag    <= 1'b0;
            cnt        <= '0;
            ack        <= 1'b0;
            rddata     <= '0;
            spram_addr <= '0;
            spram_din  <= '0;
            spram_wren <= 1'b0;
            spram_cs   <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_flag    <= wr_flag_nxt;
            cnt        <= cnt_nxt;
            ack        <= ack_nxt;
            rddata     <= rddata_nxt;
            spram_addr <= addr_nxt;
            spram_din  <= din_nxt;
            spram_wren <= wren_nxt;
            spram_cs   <= cs_nxt;
        end
    end

    // Next state and next register values; strobes default low, data holds.
    always_comb begin
        state_nxt   = state;
        wr_flag_nxt = wr_flag;
        cnt_nxt     = cnt;
        ack_nxt     = 1'b0;
        rddata_nxt  = rddata;
        addr_nxt    = spram_addr;
        din_nxt     = spram_din;
        wren_nxt    = 1'b0;
        cs_nxt      = 1'b0;

        case (state)
            IDLE: begin
                // The command is sampled only here; later bus changes are ignored.
                if (bus.bus_cyc) begin
                    addr_nxt    = bus.bus_addr;
                    din_nxt     = bus.bus_wrdata;
                    wr_flag_nxt = bus.bus_write;
                    wren_nxt    = bus.bus_write;
                    cs_nxt      = 1'b1;
                    state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.bus_cyc) begin
                    // Abort; a write strobed this cycle has already landed.
                    state_nxt = IDLE;
                end else if (wr_flag) begin
                    ack_nxt   = 1'b1;
                    state_nxt = ACK;
                end else begin
                    cnt_nxt   = CNT_W'(RD_LATENCY - 1);
                    cs_nxt    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // Abort wins over capture, so an aborted read never touches rddata.
                if (!bus.bus_cyc) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    rddata_nxt = spram_dout;
                    ack_nxt    = 1'b1;
                    state_nxt  = ACK;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                    cs_nxt  = 1'b1;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/spram_bus_ctrl.md
SPRAM_BUS_CTRL -- requirements
Module: spram_bus_ctrl

Interface
REQ-001 Parameter ADDR_W, default 14, bus and SPRAM word-address width.
REQ-002 Parameter DATA_W, default 16, bus and SPRAM data width.
REQ-003 Parameter RD_LATENCY, default 1, legal range 1..4; the number of clocks from SPRAM address issue to spram_dout valid.
REQ-004 Port clk  in  1  single clock; all state is updated on its rising edge.
REQ-005 Port rst  in  1  asynchronous, active-low reset.
REQ-006 Port bus_cyc  in  1  CPU request; held high until bus_ack is seen.
REQ-007 Port bus_write  in  1  1 = write, 0 = read; stable while bus_cyc is high.
REQ-008 Port bus_addr  in  ADDR_W  word address; stable while bus_cyc is high.
REQ-009 Port bus_wrdata  in  DATA_W  write data; stable while bus_cyc is high.
REQ-010 Port bus_rddata  out  DATA_W  registered read data.
REQ-011 Port bus_ack  out  1  registered one-cycle completion pulse.
REQ-012 Port spram_addr  out  ADDR_W  registered SPRAM address.
REQ-013 Port spram_din  out  DATA_W  registered SPRAM write data.
REQ-014 Port spram_wren  out  1  registered SPRAM write enable.
REQ-015 Port spram_cs  out  1  registered SPRAM chip select.
REQ-016 Port spram_dout  in  DATA_W  SPRAM read data.

Function
REQ-017 The FSM SHALL have four states: IDLE, ISSUE, WAIT and ACK; reset state is IDLE.
REQ-018 IDLE, bus_cyc=1: on the edge, latch bus_addr, bus_wrdata and bus_write into spram_addr, spram_din and an internal write flag, then go to ISSUE.
  - spram_wren SHALL be set to bus_write.
  - spram_cs SHALL be set to 1.
REQ-019 IDLE, bus_cyc=0: remain in IDLE.
  - spram_cs and spram_wren SHALL remain 0.
  - spram_addr and spram_din SHALL hold their last values.
REQ-020 ISSUE with write flag and bus_cyc=1: go to ACK; spram_wren returns to 0, so it is high for exactly one cycle per write.
REQ-021 ISSUE with read flag and bus_cyc=1: go to WAIT and load the wait counter with RD_LATENCY-1.
  - spram_cs stays 1.
  - spram_wren stays 0.
REQ-022 WAIT: decrement the counter each cycle.
  - When the counter is 0, capture spram_dout into bus_rddata on that edge, go to ACK and drop spram_cs.
REQ-023 ACK: bus_ack SHALL be 1 for exactly this cycle.
  - bus_cyc SHALL be ignored in ACK.
  - The next state SHALL be IDLE unconditionally.
REQ-024 Latency: request first sampled in cycle N gives:
  - write: spram_wren=1 in N+1, bus_ack in N+2;
  - read: bus_ack and valid bus_rddata in N+2+RD_LATENCY (N+3 at default).
REQ-025 Throughput: back-to-back requests are accepted in the IDLE cycle after ACK.
  - Write every 3 cycles.
  - Read every 3+RD_LATENCY cycles.
REQ-026 Abort: bus_cyc=0 in ISSUE or WAIT SHALL go to IDLE without asserting bus_ack.
  - spram_cs and spram_wren SHALL drop in the next cycle.
  - bus_rddata SHALL NOT be updated.
  - A write already issued in ISSUE is not undone.
REQ-027 bus_rddata SHALL change only on a read capture; it holds its value across writes, aborts and idle cycles.
REQ-028 bus_ack SHALL never be asserted in two consecutive cycles.
REQ-029 spram_wren SHALL never be 1 while spram_cs is 0.
REQ-030 All ADDR_W address values SHALL map directly to SPRAM with no decode, offset or wrap logic.
REQ-031 bus_write and bus_addr SHALL be sampled only in IDLE; changes during an access have no effect.

Reset
REQ-032 While rst=0, all of the following SHALL be 0 immediately, independent of clk: state=IDLE, bus_ack, bus_rddata, spram_addr, spram_din, spram_wren, spram_cs and the wait counter.
REQ-033 Reset asserted mid-access SHALL discard the access with no bus_ack.
REQ-034 After rst returns to 1, the first edge SHALL be able to accept a request already present on bus_cyc.

Verification
REQ-035 Write: cyc=1, write=1, addr=0x0123, wrdata=0xBEEF sampled in cycle 0 -> cycle 1: spram_wren=1, cs=1, addr=0x0123, din=0xBEEF; cycle 2: bus_ack=1; cycle 3: wren=0, cs=0.
REQ-036 Read, RD_LATENCY=1, SPRAM model holds 0xBEEF at 0x0123 -> cs=1 in cycles 1-2, bus_ack=1 with bus_rddata=0xBEEF in cycle 3.
REQ-037 RD_LATENCY=3 read of 0x3FFF holding 0x5A5A -> bus_ack in cycle 5 with 0x5A5A; spram_cs high in cycles 1-4.
REQ-038 Back-to-back: write 0x0001->addr 0x0000, then read addr 0x0000 requested in the IDLE cycle after ACK -> read returns 0x0001; bus_ack never high two cycles running.
REQ-039 Abort: read started, bus_cyc dropped in WAIT -> no bus_ack; bus_rddata keeps its previous value (0xBEEF); FSM back in IDLE the next cycle.
REQ-040 Reset: rst=0 asserted between clock edges during WAIT -> all outputs 0 before the next edge; a request held on bus_cyc after release completes normally.
